multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//  Moore FSM that sequences the shared multi-cycle RV32I datapath: one ALU, one unified
//  memory port, and the IR, PC, oldPC, data and ALUOut registers.
//  Drives every enable and mux select, one state per cycle.
//  Waits on the memory ready handshake. Replaces the single-cycle combinational controller.
// PARAMETERS
//  CNT_W         32  width of perf counters (MULTICYCLE_PERF_CNT_EN only)
// PORTS
//  i_clk               in   1  clock, rising edge
//  i_arst              in   1  async active-high reset
//  i_operand           in   7  IR[6:0]
//  i_funct3            in   3  IR[14:12]
//  i_funct7bit5        in   1  IR[30]
//  i_zero              in   1  ALU result == 0
//  i_memReady          in   1  memory access completes this cycle
//  o_pcWriteEn         out  1  load PC (also oldPC/IR in FETCH)
//  o_irWriteEn         out  1  load IR and oldPC
//  o_adrSrc            out  1  mem address: 0=PC, 1=ALUOut
//  o_memWriteEn        out  1  memory write strobe
//  o_regWriteEn        out  1  register file write
//  o_resultSrc         out  2  00=ALUOut 01=memData 10=ALU result direct
//  o_aluSrcA           out  2  00=PC 01=oldPC 10=rs1
//  o_aluSrcB           out  2  00=rs2 01=immExt 10=const 4
//  o_aluLogicOperation out  4  {sub/sra bit, funct3}; ADD=4'b0000, SUB=4'b1000
//  o_illegal           out  1  one-cycle pulse in DECODE on unsupported opcode
// BEHAVIOUR
//  States: FETCH DECODE MEMADR MEMREAD MEMWB MEMWRITE EXECR EXECI ALUWB BEQ JAL.
//  Reset: i_arst high -> state=FETCH asynchronously; all enables and o_illegal=0;
//   selects=0; ALU op=ADD. First state after release is FETCH.
//  FETCH: adrSrc=0, aluSrcA=00, aluSrcB=10, ADD, resultSrc=10. Holds while !i_memReady.
//   On i_memReady: irWriteEn=1, pcWriteEn=1 (PC<=PC+4) -> DECODE.
//  DECODE: aluSrcA=01, aluSrcB=01, ADD (ALUOut<=oldPC+imm). Next state by opcode:
//   0000011/0100011->MEMADR 0110011->EXECR 0010011->EXECI 1100011->BEQ 1101111->JAL.
//   Any other opcode -> o_illegal=1 for that cycle, then FETCH; no state written.
//  MEMADR: aluSrcA=10, aluSrcB=01, ADD. lw->MEMREAD, sw->MEMWRITE.
//  MEMREAD: adrSrc=1. Holds until i_memReady -> MEMWB.
//  MEMWB: resultSrc=01, regWriteEn=1 -> FETCH.
//  MEMWRITE: adrSrc=1, memWriteEn=1 held until i_memReady -> FETCH.
//  EXECR: aluSrcA=10, aluSrcB=00, op={funct7bit5,funct3} -> ALUWB.
//  EXECI: aluSrcA=10, aluSrcB=01, op={funct3==101 ? funct7bit5 : 0, funct3} -> ALUWB.
//  ALUWB: resultSrc=00, regWriteEn=1 -> FETCH.
//  BEQ: aluSrcA=10, aluSrcB=00, SUB, resultSrc=00 (target=ALUOut).
//   pcWriteEn=i_zero -> FETCH.
//  JAL: aluSrcA=01, aluSrcB=10, ADD, resultSrc=00, pcWriteEn=1 (PC<=ALUOut) -> ALUWB.
//   rd<=oldPC+4.
//  Latency with i_memReady tied 1: lw 5, sw 4, R/I 4, beq 3, jal 4 cycles.
//   Each cycle of ready low adds one cycle.
//  Never: regWriteEn and memWriteEn together; pcWriteEn outside FETCH/BEQ/JAL.
//  i_arst mid-instruction aborts it; a MEMWRITE cut by reset deasserts memWriteEn
//   immediately.
//  Inputs sampled only in the states listed; i_operand must stay stable (it comes from IR).
// CONFIGURATION
//  MULTICYCLE_PERF_CNT_EN defined: adds outputs o_cycleCnt[CNT_W] and o_instRetired[CNT_W].
//   o_cycleCnt +1 every cycle out of reset. o_instRetired +1 on each return to FETCH
//   from MEMWB, MEMWRITE, ALUWB or BEQ. Illegal-opcode returns are not counted.
//   Both wrap at 2^CNT_W-1 -> 0 and reset to 0.
//  Not defined: no counters, no extra ports or flops; FSM behaviour identical.
// TESTING
//  lw with ready=1 -> states F,D,MA,MR,MWB; regWriteEn=1 only in cycle 5, resultSrc=01.
//  sw with ready low 3 cycles in MEMWRITE -> memWriteEn high 4 cycles; regWriteEn never 1.
//  beq, i_zero=1 -> pcWriteEn=1 in BEQ, 3 cycles total.
//   i_zero=0 -> pcWriteEn only in FETCH.
//  R-type sub (funct7bit5=1, funct3=000) -> op=4'b1000 in EXECR.
//   srai -> 4'b1101; addi with IR[30]=1 -> 4'b0000.
//  opcode 7'b1111111 -> o_illegal pulse 1 cycle in DECODE, next state FETCH, no writes.
//  i_arst asserted in MEMWRITE -> memWriteEn 0 same cycle, FETCH after release.
//   With PERF_EN, counters read 0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle RV32I controller and its datapath.
// The master side is the controller: it consumes instruction fields and
// status, and drives every enable and mux select. The slave side is the
// datapath, which supplies the fields and status and consumes the controls.
interface multicycle_controller_if;
  logic [6:0] i_operand;
  logic [2:0] i_funct3;
  logic       i_funct7bit5;
  logic       i_zero;
  logic       i_memReady;

  logic       o_pcWriteEn;
  logic       o_irWriteEn;
  logic       o_adrSrc;
  logic       o_memWriteEn;
  logic       o_regWriteEn;
  logic [1:0] o_resultSrc;
  logic [1:0] o_aluSrcA;
  logic [1:0] o_aluSrcB;
  logic [3:0] o_aluLogicOperation;
  logic       o_illegal;

  modport master (
    input  i_operand, i_funct3, i_funct7bit5, i_zero, i_memReady,
    output o_pcWriteEn, o_irWriteEn, o_adrSrc, o_memWriteEn, o_regWriteEn,
           o_resultSrc, o_aluSrcA, o_aluSrcB, o_aluLogicOperation, o_illegal
  );

  modport slave (
    output i_operand, i_funct3, i_funct7bit5, i_zero, i_memReady,
    input  o_pcWriteEn, o_irWriteEn, o_adrSrc, o_memWriteEn, o_regWriteEn,
           o_resultSrc, o_aluSrcA, o_aluSrcB, o_aluLogicOperation, o_illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the shared multi-cycle RV32I datapath (one ALU, one
// unified memory port, IR/PC/oldPC/data/ALUOut registers). One state per
// cycle; memory states wait on the ready handshake.
// Optional feature: define MULTICYCLE_PERF_CNT_EN to add the free-running
// cycle counter o_cycleCnt and retired-instruction counter o_instRetired.
module multicycle_controller
`ifdef MULTICYCLE_PERF_CNT_EN
  #(parameter int CNT_W = 32)
`endif
(
  input  logic                          i_clk,
  input  logic                          i_arst,
`ifdef MULTICYCLE_PERF_CNT_EN
  output logic [CNT_W-1:0]              o_cycleCnt,
  output logic [CNT_W-1:0]              o_instRetired,
`endif
  multicycle_controller_if.master       bus
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  state_t state_q, state_d;

  // State register; reset forces FETCH immediately, aborting any instruction.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore outputs; everything is held at its idle value while
  // reset is asserted so a cut memory write drops its strobe the same cycle.
  always_comb begin
    state_d                 = state_q;
    bus.o_pcWriteEn         = 1'b0;
    bus.o_irWriteEn         = 1'b0;
    bus.o_adrSrc            = 1'b0;
    bus.o_memWriteEn        = 1'b0;
    bus.o_regWriteEn        = 1'b0;
    bus.o_resultSrc         = 2'b00;
    bus.o_aluSrcA           = 2'b00;
    bus.o_aluSrcB           = 2'b00;
    bus.o_aluLogicOperation = ALU_ADD;
    bus.o_illegal           = 1'b0;

    if (i_arst) begin
      state_d = FETCH;
    end else begin
      unique case (state_q)
        FETCH: begin
          // Memory reads at PC while the ALU forms PC+4 for the PC register.
          bus.o_adrSrc    = 1'b0;
          bus.o_aluSrcA   = 2'b00;
          bus.o_aluSrcB   = 2'b10;
          bus.o_resultSrc = 2'b10;
          if (bus.i_memReady) begin
            bus.o_irWriteEn = 1'b1;
            bus.o_pcWriteEn = 1'b1;
            state_d         = DECODE;
          end
        end

        DECODE: begin
          // Speculatively compute the branch/jump target oldPC+imm into ALUOut.
          bus.o_aluSrcA = 2'b01;
          bus.o_aluSrcB = 2'b01;
          unique case (bus.i_operand)
            OP_LOAD, OP_STORE: state_d = MEMADR;
            OP_RTYPE:          state_d = EXECR;
            OP_ITYPE:          state_d = EXECI;
            OP_BRANCH:         state_d = BEQ;
            OP_JAL:            state_d = JAL;
            default: begin
              bus.o_illegal = 1'b1;
              state_d       = FETCH;
            end
          endcase
        end

        MEMADR: begin
          bus.o_aluSrcA = 2'b10;
          bus.o_aluSrcB = 2'b01;
          state_d       = (bus.i_operand == OP_STORE) ? MEMWRITE : MEMREAD;
        end

        MEMREAD: begin
          bus.o_adrSrc = 1'b1;
          if (bus.i_memReady) begin
            state_d = MEMWB;
          end
        end

        MEMWB: begin
          bus.o_resultSrc  = 2'b01;
          bus.o_regWriteEn = 1'b1;
          state_d          = FETCH;
        end

        MEMWRITE: begin
          // Strobe stays up until memory accepts the write.
          bus.o_adrSrc     = 1'b1;
          bus.o_memWriteEn = 1'b1;
          if (bus.i_memReady) begin
            state_d = FETCH;
          end
        end

        EXECR: begin
          bus.o_aluSrcA           = 2'b10;
          bus.o_aluSrcB           = 2'b00;
          bus.o_aluLogicOperation = {bus.i_funct7bit5, bus.i_funct3};
          state_d                 = ALUWB;
        end

        EXECI: begin
          // IR[30] is part of the immediate except for the shift-right forms.
          bus.o_aluSrcA           = 2'b10;
          bus.o_aluSrcB           = 2'b01;
          bus.o_aluLogicOperation = {(bus.i_funct3 == 3'b101) ? bus.i_funct7bit5 : 1'b0,
                                     bus.i_funct3};
          state_d                 = ALUWB;
        end

        ALUWB: begin
          bus.o_resultSrc  = 2'b00;
          bus.o_regWriteEn = 1'b1;
          state_d          = FETCH;
        end

        BEQ: begin
          // Compare rs1-rs2; the target already sits in ALUOut from DECODE.
          bus.o_aluSrcA           = 2'b10;
          bus.o_aluSrcB           = 2'b00;
          bus.o_aluLogicOperation = ALU_SUB;
          bus.o_resultSrc         = 2'b00;
          bus.o_pcWriteEn         = bus.i_zero;
          state_d                 = FETCH;
        end

        JAL: begin
          // PC takes the target from ALUOut while the ALU forms the link oldPC+4.
          bus.o_aluSrcA   = 2'b01;
          bus.o_aluSrcB   = 2'b10;
          bus.o_resultSrc = 2'b00;
          bus.o_pcWriteEn = 1'b1;
          state_d         = ALUWB;
        end

        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

`ifdef MULTICYCLE_PERF_CNT_EN
  logic [CNT_W-1:0] cycleCnt_q, cycleCnt_d;
  logic [CNT_W-1:0] instRetired_q, instRetired_d;
  logic             retire;

  // An instruction retires on a normal return to FETCH; illegal-opcode
  // returns from DECODE are deliberately excluded.
  always_comb begin
    retire = 1'b0;
    unique case (state_q)
      MEMWB, ALUWB, BEQ: retire = 1'b1;
      MEMWRITE:          retire = bus.i_memReady;
      default:           retire = 1'b0;
    endcase
    cycleCnt_d    = cycleCnt_q + CNT_W'(1);
    instRetired_d = retire ? instRetired_q + CNT_W'(1) : instRetired_q;
  end

  // Free-running counters; natural wrap at 2^CNT_W.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      cycleCnt_q    <= '0;
      instRetired_q <= '0;
    end else begin
      cycleCnt_q    <= cycleCnt_d;
      instRetired_q <= instRetired_d;
    end
  end

  assign o_cycleCnt    = cycleCnt_q;
  assign o_instRetired = instRetired_q;
`endif

endmodule
